inst_sram_responder: RTL and testbench
======================================

Name: inst_sram_responder

Overview:
- Slave/responder end of the instruction-SRAM interface driven by the fetch stage.
- Accepts `inst_sram_en`/`inst_sram_addr` requests and returns the instruction word the cycle after a hit.
- Holds one LINE_WORDS-word line buffer; on a miss it stalls fetch and refills the line from a slower word-serial backing memory port.
- Sits between the CPU fetch stage and the SoC instruction memory/bridge.

Parameters:
- LINE_WORDS, 4, words per line buffer; power of two, minimum 2.
- ADDR_W, 32, instruction address width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active high.
- inst_sram_en  in  1  fetch request valid.
- inst_sram_addr  in  ADDR_W  fetch byte address; bits [1:0] ignored.
- inst_sram_rdata  out  32  instruction word for the last accepted request.
- inst_rdata_valid  out  1  one-cycle pulse: inst_sram_rdata holds the response.
- inst_stall  out  1  fetch must hold its address and deassert en.
- flush  in  1  invalidate line buffer.
- mem_req  out  1  backing read request, held until granted.
- mem_addr  out  ADDR_W  word-aligned backing read address.
- mem_gnt  in  1  backing read done; mem_rdata valid this cycle.
- mem_rdata  in  32  backing read data.

Behaviour:
- Decided: one clock `clk`; `rst` is synchronous, active high.
- Reset values:
  - state=IDLE, line_valid=0, inst_stall=0.
  - inst_rdata_valid=0, inst_sram_rdata=0.
  - mem_req=0, mem_addr=0, word counter=0.
- Address fields:
  - Word index = addr[2+log2(LINE_WORDS)-1:2].
  - Tag = addr[ADDR_W-1:2+log2(LINE_WORDS)].
- inst_stall = (state != IDLE). It is a pure register decode with no combinational path from inst_sram_en, so there is no loop with fetch's en = ~stall.
- Requests are sampled only in IDLE. inst_sram_en is ignored in FILL.
- IDLE, en=1, hit (line_valid and tag match):
  - Next edge: inst_sram_rdata <= line[index], inst_rdata_valid <= 1.
  - Stay IDLE. Back-to-back hits give one word per cycle.
- IDLE, en=1, miss:
  - Latch req_addr and tag; line_valid <= 0.
  - Next edge: state <= FILL, counter <= 0, mem_req <= 1, mem_addr <= {tag, counter=0, 2'b00}.
  - inst_rdata_valid stays 0.
- FILL:
  - Each cycle with mem_gnt=1: line[counter] <= mem_rdata; counter increments; mem_addr advances by 4.
  - mem_req stays 1 until the last grant. It drops on the edge that captures word LINE_WORDS-1.
  - mem_gnt with mem_req=0 is ignored.
- Fill completion (grant of word LINE_WORDS-1), on the same edge:
  - state <= IDLE.
  - inst_sram_rdata <= word at req index; the current mem_rdata is forwarded if the index is the last word.
  - inst_rdata_valid <= 1.
  - line_valid <= ~drop.
- Miss latency: 1 + LINE_WORDS grant cycles. With mem_gnt tied high, inst_stall is high for exactly LINE_WORDS cycles.
- inst_rdata_valid is a single-cycle pulse per accepted request. It is 0 in every other cycle.
- inst_sram_rdata holds its value between responses.
- flush:
  - In IDLE: line_valid <= 0 on the next edge. A request in the same cycle as flush is treated as a miss.
  - During FILL: set drop. The fill completes and the response is still returned, but line_valid stays 0. drop clears on return to IDLE.
- rst mid-FILL: all state returns to reset values on the next edge, mem_req drops immediately, no response is issued, and line contents become don't-care.
- Line storage is not reset. Only line_valid gates its use.

Test Plan:
- Reset then en=1, addr=0xBFC00000, mem_gnt=1 constant, mem_rdata=addr-based pattern:
  - inst_stall high 4 cycles.
  - mem_addr sequence 0xBFC00000, 04, 08, 0C.
  - inst_rdata_valid pulses with rdata = word@0xBFC00000.
- After that fill, en=1 for addrs 0xBFC00004, 08, 0C on consecutive cycles: three consecutive valid pulses, correct words, inst_stall stays 0, mem_req stays 0.
- Miss at 0xBFC0000C (last word):
  - Response data equals the mem_rdata forwarded on the final grant.
  - Then 0xBFC00010 misses with mem_addr starting at 0xBFC00010.
- Fill with mem_gnt pattern 1,0,0,1,1,0,1:
  - mem_req is held through the gaps.
  - Exactly 4 words are captured; the response comes after the 4th grant.
  - en toggling during FILL has no effect.
- flush asserted mid-fill for addr 0xBFC00020:
  - Response still returned.
  - A following request to 0xBFC00024 misses and refills.
  - Separately, flush in IDLE forces a miss on a previously hit line.
- rst asserted after 2 grants of a fill:
  - Next cycle: inst_stall=0, mem_req=0, inst_rdata_valid=0, rdata=0.
  - A request to the same address misses.

Source files
------------

// File: rtl/inst_sram_responder.sv
// Instruction-SRAM responder: one-line buffer serving fetch hits in one cycle,
// refilling the line word-serially from a backing memory port on a miss.
module inst_sram_responder #(
    parameter int unsigned LINE_WORDS = 4,
    parameter int unsigned ADDR_W     = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inst_sram_en,
    input  logic [ADDR_W-1:0] inst_sram_addr,
    output logic [31:0]       inst_sram_rdata,
    output logic              inst_rdata_valid,
    output logic              inst_stall,
    input  logic              flush,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_gnt,
    input  logic [31:0]       mem_rdata
);

    localparam int unsigned IDX_W = $clog2(LINE_WORDS);
    localparam int unsigned OFF_W = IDX_W + 2;
    localparam int unsigned TAG_W = ADDR_W - OFF_W;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LINE_WORDS - 1);

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_t;

    state_t            state;
    logic              line_valid;
    logic              drop;
    logic [TAG_W-1:0]  line_tag;
    logic [IDX_W-1:0]  req_idx;
    logic [IDX_W-1:0]  cnt;
    logic [31:0]       line [LINE_WORDS];

    logic [TAG_W-1:0]  cur_tag;
    logic [IDX_W-1:0]  cur_idx;
    logic              hit;
    logic              grant;
    logic              last_grant;
    logic              unused_addr_bits;

    // Request decode; a flush in the same cycle as a request forces a miss.
    assign cur_tag          = inst_sram_addr[ADDR_W-1:OFF_W];
    assign cur_idx          = inst_sram_addr[OFF_W-1:2];
    assign hit              = line_valid && !flush && (cur_tag == line_tag);
    assign grant            = (state == FILL) && mem_req && mem_gnt;
    assign last_grant       = grant && (cnt == LAST_IDX);
    assign unused_addr_bits = ^inst_sram_addr[1:0];

    // Line storage is deliberately unreset; line_valid alone gates its use.
    always_ff @(posedge clk) begin
        if (grant) begin
            line[cnt] <= mem_rdata;
        end
    end

    // Control FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            line_valid       <= 1'b0;
            drop             <= 1'b0;
            line_tag         <= '0;
            req_idx          <= '0;
            cnt              <= '0;
            inst_stall       <= 1'b0;
            inst_rdata_valid <= 1'b0;
            inst_sram_rdata  <= 32'h0;
            mem_req          <= 1'b0;
            mem_addr         <= '0;
        end else begin
            inst_rdata_valid <= 1'b0;
            case (state)
                IDLE: begin
                    drop <= 1'b0;
                    if (inst_sram_en && hit) begin
                        inst_sram_rdata  <= line[cur_idx];
                        inst_rdata_valid <= 1'b1;
                    end else if (inst_sram_en) begin
                        line_tag   <= cur_tag;
                        req_idx    <= cur_idx;
                        line_valid <= 1'b0;
                        cnt        <= '0;
                        mem_req    <= 1'b1;
                        mem_addr   <= {cur_tag, IDX_W'(0), 2'b00};
                        inst_stall <= 1'b1;
                        state      <= FILL;
                    end else if (flush) begin
                        line_valid <= 1'b0;
                    end
                end
                FILL: begin
                    if (flush) begin
                        drop <= 1'b1;
                    end
                    if (grant) begin
                        cnt      <= cnt + IDX_W'(1);
                        mem_addr <= mem_addr + ADDR_W'(4);
                    end
                    // Final grant: the requested word may be arriving this cycle.
                    if (last_grant) begin
                        mem_req          <= 1'b0;
                        inst_stall       <= 1'b0;
                        inst_rdata_valid <= 1'b1;
                        inst_sram_rdata  <= (req_idx == LAST_IDX) ? mem_rdata : line[req_idx];
                        line_valid       <= !(drop || flush);
                        state            <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_inst_sram_responder.sv
// Self-checking bench for inst_sram_responder: scoreboard of expected fetch
// words, backing memory modelled as an address/salt-derived data pattern.
module tb_inst_sram_responder;

    logic        clk;
    logic        rst;
    logic        inst_sram_en;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_rdata;
    logic        inst_rdata_valid;
    logic        inst_stall;
    logic        flush;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt;
    logic [31:0] mem_rdata;

    int          total;
    int          bad;
    logic [31:0] salt;
    logic [31:0] exp_q [$];

    inst_sram_responder #(.LINE_WORDS(4), .ADDR_W(32)) dut (
        .clk              (clk),
        .rst              (rst),
        .inst_sram_en     (inst_sram_en),
        .inst_sram_addr   (inst_sram_addr),
        .inst_sram_rdata  (inst_sram_rdata),
        .inst_rdata_valid (inst_rdata_valid),
        .inst_stall       (inst_stall),
        .flush            (flush),
        .mem_req          (mem_req),
        .mem_addr         (mem_addr),
        .mem_gnt          (mem_gnt),
        .mem_rdata        (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] word_of(input logic [31:0] a, input logic [31:0] s);
        logic [31:0] w;
        w = {a[31:2], 2'b00};
        return ({w[15:0], ~w[31:16]} ^ 32'h1357_9BDF) ^ s;
    endfunction

    assign mem_rdata = mem_req ? word_of(mem_addr, salt) : 32'hDEAD_BEEF;

    // Advance one clock, then compare any response against the scoreboard.
    task automatic step();
        logic [31:0] exp;
        @(posedge clk);
        #1;
        if (inst_rdata_valid) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_resp got=%h expected=none", inst_sram_rdata);
            end else begin
                exp = exp_q.pop_front();
                if (inst_sram_rdata !== exp) begin
                    bad++;
                    $display("FAIL resp_data got=%h expected=%h", inst_sram_rdata, exp);
                end
            end
        end
    endtask

    task automatic issue(input logic [31:0] a);
        inst_sram_en   = 1'b1;
        inst_sram_addr = a;
        exp_q.push_back(word_of(a, salt));
        step();
        inst_sram_en = 1'b0;
    endtask

    task automatic wait_resp(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            step();
            n++;
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL resp_timeout got=%0d_pending expected=0_pending", exp_q.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        total++;
        if ({inst_stall, mem_req, inst_rdata_valid} !== 3'b000 || inst_sram_rdata !== 32'h0 || mem_addr !== 32'h0) begin
            bad++;
            $display("FAIL reset_state got=stall%b req%b vld%b rd=%h ma=%h expected=all_zero",
                     inst_stall, mem_req, inst_rdata_valid, inst_sram_rdata, mem_addr);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_first_fill();
        issue(32'hBFC0_0000);
        for (int i = 0; i < 4; i++) begin
            total++;
            if (inst_stall !== 1'b1 || mem_req !== 1'b1 || mem_addr !== 32'hBFC0_0000 + 32'(4 * i)) begin
                bad++;
                $display("FAIL first_fill_cyc%0d got=stall%b req%b ma=%h expected=stall1 req1 ma=%h",
                         i, inst_stall, mem_req, mem_addr, 32'hBFC0_0000 + 32'(4 * i));
            end
            step();
        end
        total++;
        if (inst_stall !== 1'b0 || mem_req !== 1'b0 || exp_q.size() != 0) begin
            bad++;
            $display("FAIL first_fill_done got=stall%b req%b pend%0d expected=stall0 req0 pend0",
                     inst_stall, mem_req, exp_q.size());
        end
    endtask

    task automatic test_back_to_back();
        inst_sram_en = 1'b1;
        for (int i = 1; i < 4; i++) begin
            inst_sram_addr = 32'hBFC0_0000 + 32'(4 * i);
            exp_q.push_back(word_of(inst_sram_addr, salt));
            step();
            total++;
            if (inst_rdata_valid !== 1'b1 || inst_stall !== 1'b0 || mem_req !== 1'b0) begin
                bad++;
                $display("FAIL b2b_hit%0d got=vld%b stall%b req%b expected=vld1 stall0 req0",
                         i, inst_rdata_valid, inst_stall, mem_req);
            end
        end
        inst_sram_en = 1'b0;
        step();
        total++;
        if (inst_rdata_valid !== 1'b0) begin
            bad++;
            $display("FAIL b2b_pulse_end got=%b expected=0", inst_rdata_valid);
        end
    endtask

    task automatic test_last_word();
        salt  = 32'h00FF_00FF;
        flush = 1'b1;
        step();
        flush = 1'b0;
        issue(32'hBFC0_000C);
        total++;
        if (inst_stall !== 1'b1 || mem_addr !== 32'hBFC0_0000) begin
            bad++;
            $display("FAIL last_word_miss got=stall%b ma=%h expected=stall1 ma=bfc00000", inst_stall, mem_addr);
        end
        wait_resp(20);
        issue(32'hBFC0_0010);
        total++;
        if (mem_req !== 1'b1 || mem_addr !== 32'hBFC0_0010) begin
            bad++;
            $display("FAIL next_line_miss got=req%b ma=%h expected=req1 ma=bfc00010", mem_req, mem_addr);
        end
        wait_resp(20);
    endtask

    task automatic test_gnt_gaps();
        int gp [7] = '{1, 0, 0, 1, 1, 0, 1};
        int grants;
        grants = 0;
        salt = 32'h0F0F_1234;
        issue(32'hBFC0_0044);
        for (int i = 0; i < 7; i++) begin
            mem_gnt        = gp[i][0];
            inst_sram_en   = i[0];
            inst_sram_addr = 32'h1000_0000 + 32'(4 * i);
            total++;
            if (mem_req !== 1'b1 || mem_addr !== 32'hBFC0_0040 + 32'(4 * grants) || exp_q.size() != 1) begin
                bad++;
                $display("FAIL gap_cyc%0d got=req%b ma=%h pend%0d expected=req1 ma=%h pend1",
                         i, mem_req, mem_addr, exp_q.size(), 32'hBFC0_0040 + 32'(4 * grants));
            end
            grants += gp[i];
            step();
        end
        inst_sram_en = 1'b0;
        mem_gnt      = 1'b1;
        total++;
        if (exp_q.size() != 0 || inst_stall !== 1'b0 || mem_req !== 1'b0) begin
            bad++;
            $display("FAIL gap_done got=pend%0d stall%b req%b expected=pend0 stall0 req0",
                     exp_q.size(), inst_stall, mem_req);
        end
        for (int i = 0; i < 4; i++) begin
            issue(32'hBFC0_0040 + 32'(4 * i));
            total++;
            if (inst_stall !== 1'b0 || mem_req !== 1'b0) begin
                bad++;
                $display("FAIL gap_word%0d_hit got=stall%b req%b expected=stall0 req0", i, inst_stall, mem_req);
            end
        end
    endtask

    task automatic test_flush();
        salt = 32'hA0A0_0505;
        issue(32'hBFC0_0020);
        flush = 1'b1;
        step();
        flush = 1'b0;
        wait_resp(20);
        issue(32'hBFC0_0024);
        total++;
        if (mem_req !== 1'b1 || inst_stall !== 1'b1) begin
            bad++;
            $display("FAIL flush_fill_refetch got=req%b stall%b expected=req1 stall1", mem_req, inst_stall);
        end
        wait_resp(20);
        issue(32'hBFC0_0028);
        total++;
        if (mem_req !== 1'b0 || inst_stall !== 1'b0) begin
            bad++;
            $display("FAIL refill_hit got=req%b stall%b expected=req0 stall0", mem_req, inst_stall);
        end
        flush = 1'b1;
        step();
        flush = 1'b0;
        issue(32'hBFC0_0028);
        total++;
        if (mem_req !== 1'b1 || inst_stall !== 1'b1) begin
            bad++;
            $display("FAIL idle_flush_miss got=req%b stall%b expected=req1 stall1", mem_req, inst_stall);
        end
        wait_resp(20);
    endtask

    task automatic test_reset_mid_fill();
        salt = 32'h7777_0000;
        issue(32'hBFC0_0080);
        step();
        step();
        rst = 1'b1;
        exp_q.delete();
        step();
        rst = 1'b0;
        total++;
        if ({inst_stall, mem_req, inst_rdata_valid} !== 3'b000 || inst_sram_rdata !== 32'h0 || mem_addr !== 32'h0) begin
            bad++;
            $display("FAIL rst_mid_fill got=stall%b req%b vld%b rd=%h ma=%h expected=all_zero",
                     inst_stall, mem_req, inst_rdata_valid, inst_sram_rdata, mem_addr);
        end
        step();
        issue(32'hBFC0_0080);
        total++;
        if (mem_req !== 1'b1 || inst_stall !== 1'b1 || mem_addr !== 32'hBFC0_0080) begin
            bad++;
            $display("FAIL rst_then_miss got=req%b stall%b ma=%h expected=req1 stall1 ma=bfc00080",
                     mem_req, inst_stall, mem_addr);
        end
        wait_resp(20);
    endtask

    initial begin
        total          = 0;
        bad            = 0;
        salt           = 32'h0;
        rst            = 1'b1;
        inst_sram_en   = 1'b0;
        inst_sram_addr = 32'h0;
        flush          = 1'b0;
        mem_gnt        = 1'b1;
        test_reset();
        test_first_fill();
        test_back_to_back();
        test_last_word();
        test_gnt_gaps();
        test_flush();
        test_reset_mid_fill();
        step();
        step();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL final_drain got=%0d_pending expected=0_pending", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
